// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   FETCH_RESET_PC : default first fetch address after reset
//   FETCH_DEPTH    : default instruction buffer depth (= max requests in flight)
//   fetch_state_t  : FETCH_RUN issues requests, FETCH_DRAIN waits out stale responses
//   fetch_entry_t  : one buffered instruction {pc, inst}
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_1000;
  localparam int          FETCH_DEPTH    = 2;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch instruction buffer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write one entry
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over a same-cycle push
//   head       : current head entry (undefined when empty)
//   count      : number of stored entries
//   empty      : count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches under a credit limit,
// buffers returned instructions for the decoder and handles redirects by
// flushing the buffer and dropping responses to already-issued requests.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt : fetch request handshake
//   imem_rvalid/imem_rdata      : in-order read responses
//   redirect_valid/redirect_pc  : new fetch target from execute
//   inst_valid/inst_ready       : decoder handshake
//   inst/inst_pc                : instruction word and its address
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] drop_redir;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_in;
  logic          credit_ok;
  logic          accept;
  logic          rsp;
  logic          keep;
  logic          pop;

  // Buffered entries plus in-flight requests may never exceed DEPTH, so every
  // response always has a free FIFO slot waiting for it.
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
  assign imem_req   = rst_n && !redirect_valid && credit_ok && (state == FETCH_RUN);
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp        = imem_rvalid && (outstanding != '0);
  assign keep       = rsp && !redirect_valid && (drop == '0);
  assign drop_redir = outstanding - CW'(rsp);
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst       = fifo_empty ? 32'h0 : fifo_head.inst;
  assign inst_pc    = fifo_empty ? RESET_PC : fifo_head.pc;
  assign fifo_in    = '{pc: resp_pc, inst: imem_rdata};

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    if (redirect_valid) begin
      // Everything still in flight (less any response landing now) is stale.
      drop_nxt  = drop_redir;
      state_nxt = (drop_redir != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else begin
      if (rsp && (drop != '0)) drop_nxt = drop - 1'b1;
      if ((state == FETCH_DRAIN) && (drop_nxt == '0)) state_nxt = FETCH_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_nxt;
      drop        <= drop_nxt;
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (keep)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep),
    .push_data (fifo_in),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_1000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  // Memory side: accepted requests waiting for their response cycle.
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  // Reference model: requests in flight (stale once a redirect passes them)
  // and the instructions waiting for the decoder.
  typedef struct {logic [31:0] pc; bit stale;} flight_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;

  mreq_t       mem_q[$];
  flight_t     infl[$];
  ent_t        bufq[$];
  logic [31:0] m_pc;
  logic [31:0] emitted[$];
  int          emit_cyc[$];
  int          cyc;
  int          acc_cnt;
  int          total = 0;
  int          bad = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_emit(input int i);
    if (i < emitted.size()) return emitted[i];
    return 32'hBAD0_BAD1;
  endfunction

  function automatic int get_emit_cyc(input int i);
    if (i < emit_cyc.size()) return emit_cyc[i];
    return -100;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0000_1000);
    mem_q.delete();
    infl.delete();
    bufq.delete();
    emitted.delete();
    emit_cyc.delete();
    m_pc = 32'h0000_1000;
    cyc = 0;
    acc_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int lat, input bit spur);
    bit      exp_req, exp_valid, has_stale;
    flight_t e;
    @(negedge clk);
    cyc++;
    imem_gnt = gnt;
    inst_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = mem_q[0].addr ^ KEY;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = spur && (mem_q.size() == 0);
      imem_rdata = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = inst_pc; s_inst = inst;

    has_stale = 1'b0;
    foreach (infl[i]) if (infl[i].stale) has_stale = 1'b1;
    exp_req   = !redir && !has_stale && (bufq.size() + infl.size() < DEPTH);
    exp_valid = !redir && (bufq.size() > 0);
    chk1("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk1("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      chk("inst_pc", inst_pc, bufq[0].pc);
      chk("inst", inst, bufq[0].inst);
    end

    if (inst_valid && rdy) begin
      emitted.push_back(inst_pc);
      emit_cyc.push_back(cyc);
    end
    if (imem_req && gnt) begin
      mem_q.push_back('{imem_addr, cyc + lat});
      acc_cnt++;
      chk1("in_flight_limit", mem_q.size() <= DEPTH, 1'b1);
    end

    if (exp_valid && rdy) void'(bufq.pop_front());
    if (imem_rvalid && infl.size() > 0) begin
      e = infl.pop_front();
      if (!e.stale && !redir) bufq.push_back('{e.pc, imem_rdata});
    end
    if (redir) begin
      bufq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (exp_req && gnt) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    int          n_stale;
    logic [31:0] rpc;

    // Streaming with grant always high and 1-cycle latency.
    do_reset();
    step(1, 1, 0, 0, 1, 0);
    chk1("p1_req_c1", s_req, 1'b1);
    chk("p1_addr_c1", s_addr, 32'h0000_1000);
    chk1("p1_valid_c1", s_valid, 1'b0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p1_valid_c2", s_valid, 1'b0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p1_valid_c3", s_valid, 1'b1);
    chk("p1_pc_c3", s_pc, 32'h0000_1000);
    chk("p1_inst_c3", s_inst, 32'hA5A5_1000);
    repeat (6) step(1, 1, 0, 0, 1, 0);
    chk("p1_emit0", get_emit(0), 32'h0000_1000);
    chk("p1_emit1", get_emit(1), 32'h0000_1004);
    chk("p1_emit2", get_emit(2), 32'h0000_1008);

    // Decoder stalled: buffer fills, requests stop, then drains back to back.
    do_reset();
    repeat (10) step(1, 0, 0, 0, 1, 0);
    chk("p2_grants", 32'(acc_cnt), 32'd2);
    chk1("p2_req_low", s_req, 1'b0);
    chk1("p2_valid", s_valid, 1'b1);
    chk("p2_head", s_pc, 32'h0000_1000);
    repeat (2) step(1, 1, 0, 0, 1, 0);
    chk("p2_emit_n", 32'(emitted.size()), 32'd2);
    chk("p2_emit0", get_emit(0), 32'h0000_1000);
    chk("p2_emit1", get_emit(1), 32'h0000_1004);
    chk("p2_b2b", 32'(get_emit_cyc(1) - get_emit_cyc(0)), 32'd1);

    // Redirect with two requests outstanding.
    do_reset();
    step(1, 1, 0, 0, 3, 0);
    step(1, 1, 0, 0, 3, 0);
    step(1, 1, 1, 32'h0000_2003, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p3_drain_req", s_req, 1'b0);
    repeat (12) step(1, 1, 0, 0, 1, 0);
    chk("p3_first", get_emit(0), 32'h0000_2000);
    n_stale = 0;
    foreach (emitted[i]) if (emitted[i][31:12] == 20'h00001) n_stale++;
    chk("p3_no_stale", 32'(n_stale), 32'd0);

    // Redirect coinciding with rvalid, then a second redirect while draining.
    do_reset();
    step(1, 1, 0, 0, 3, 0);
    step(1, 1, 0, 0, 5, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 1, 32'h0000_2000, 1, 0);
    step(1, 1, 1, 32'h0000_3000, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p4_drain_c6", s_req, 1'b0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p4_drain_c7", s_req, 1'b0);
    step(1, 1, 0, 0, 1, 0);
    chk1("p4_req_c8", s_req, 1'b1);
    chk("p4_addr_c8", s_addr, 32'h0000_3000);
    repeat (8) step(1, 1, 0, 0, 1, 0);
    chk("p4_first", get_emit(0), 32'h0000_3000);

    // Address wrap, then asynchronous reset mid-stream.
    do_reset();
    step(1, 1, 1, 32'hFFFF_FFFC, 1, 0);
    repeat (8) step(1, 1, 0, 0, 1, 0);
    chk("p5_emit0", get_emit(0), 32'hFFFF_FFFC);
    chk("p5_emit1", get_emit(1), 32'h0000_0000);
    chk("p5_emit2", get_emit(2), 32'h0000_0004);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        do_reset();
      end else begin
        rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
        step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
             $urandom_range(11, 0) == 0, rpc, 1 + $urandom_range(2, 0),
             $urandom_range(7, 0) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
